alu_issue_arbiter: RTL and testbench

Shares the single multi-cycle alu instance between two requesters, e.g. integer issue slot 0 and slot 1. It arbitrates round-robin, latches the winner's operand set and pulses alu en for one cycle. It then waits for alu rdy, captures result/ex_result/cout and returns them to the winner over a valid/ready response channel. Only one operation is in flight at a time.

---
 rtl/alu_issue_arbiter_if.sv | 60 ++++++
 rtl/alu_issue_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_alu_issue_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_arbiter_if.sv
// Request, ALU and response bundle of the two-slot ALU issue arbiter.
// slave = arbiter side; master = requesters, ALU and response consumer.
`ifndef LEN_DATA
`define LEN_DATA 64
`endif
`ifndef LEN_TYPE_ALU
`define LEN_TYPE_ALU 5
`endif

interface alu_issue_arbiter_if #(
  parameter int DATA_W = `LEN_DATA,
  parameter int CODE_W = `LEN_TYPE_ALU
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*DATA_W-1:0] req_a;
  logic [2*DATA_W-1:0] req_b;
  logic [2*DATA_W-1:0] req_imm;
  logic [15:0]         req_cin;
  logic [2*CODE_W-1:0] req_code;

  logic                alu_en;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W-1:0]   alu_imm;
  logic [7:0]          alu_cin;
  logic [CODE_W-1:0]   alu_code;
  logic [DATA_W-1:0]   alu_result;
  logic [DATA_W-1:0]   alu_ex_result;
  logic                alu_cout;
  logic                alu_rdy;

  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [DATA_W-1:0]   rsp_result;
  logic [DATA_W-1:0]   rsp_ex_result;
  logic                rsp_cout;
  logic                rsp_err;

  modport slave (
    input  req_valid, req_a, req_b, req_imm, req_cin, req_code,
    output req_ready,
    output alu_en, alu_a, alu_b, alu_imm, alu_cin, alu_code,
    input  alu_result, alu_ex_result, alu_cout, alu_rdy,
    output rsp_valid, rsp_id, rsp_result, rsp_ex_result,
    output rsp_cout, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_a, req_b, req_imm, req_cin, req_code,
    input  req_ready,
    input  alu_en, alu_a, alu_b, alu_imm, alu_cin, alu_code,
    output alu_result, alu_ex_result, alu_cout, alu_rdy,
    input  rsp_valid, rsp_id, rsp_result, rsp_ex_result,
    input  rsp_cout, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin share of one multi-cycle ALU between two issue slots.
// Ports: clk, rst (async, active high), bus (alu_issue_arbiter_if.slave):
//   req_* per-slot requests, alu_* ALU start/operands/results,
//   rsp_* valid/ready response to the served slot.
// Option: define ALU_ISSUE_ARBITER_TIMEOUT_EN to abort a WAIT after
//   TIMEOUT cycles without alu_rdy (response flagged with rsp_err).
`ifndef LEN_DATA
`define LEN_DATA 64
`endif
`ifndef LEN_TYPE_ALU
`define LEN_TYPE_ALU 5
`endif

module alu_issue_arbiter #(
  parameter int DATA_W  = `LEN_DATA,
  parameter int CODE_W  = `LEN_TYPE_ALU,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  alu_issue_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e              state_q, state_d;
  logic                rr_q, rr_d;
  logic                alu_en_q, alu_en_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [DATA_W-1:0]   alu_imm_q, alu_imm_d;
  logic [7:0]          alu_cin_q, alu_cin_d;
  logic [CODE_W-1:0]   alu_code_q, alu_code_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_res_q, rsp_res_d;
  logic [DATA_W-1:0]   rsp_ex_q, rsp_ex_d;
  logic                rsp_cout_q, rsp_cout_d;

`ifdef ALU_ISSUE_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rsp_err_q, rsp_err_d;
`else
  logic [31:0]         unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
`endif

  logic any;
  logic win;

  // Pointer slot wins if requesting, otherwise the other slot.
  always_comb begin
    any = |bus.req_valid;
    win = bus.req_valid[rr_q] ? rr_q : ~rr_q;
  end

  // Gated by rst so no grant is visible while reset is held.
  assign bus.req_ready =
    (!rst && state_q == IDLE && any) ?
    (win ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    alu_en_d   = 1'b0;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_imm_d  = alu_imm_q;
    alu_cin_d  = alu_cin_q;
    alu_code_d = alu_code_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d   = rsp_id_q;
    rsp_res_d  = rsp_res_q;
    rsp_ex_d   = rsp_ex_q;
    rsp_cout_d = rsp_cout_q;
`ifdef ALU_ISSUE_ARBITER_TIMEOUT_EN
    cnt_d      = cnt_q;
    rsp_err_d  = rsp_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any) begin
          alu_a_d    = win ? bus.req_a[2*DATA_W-1:DATA_W]
                           : bus.req_a[DATA_W-1:0];
          alu_b_d    = win ? bus.req_b[2*DATA_W-1:DATA_W]
                           : bus.req_b[DATA_W-1:0];
          alu_imm_d  = win ? bus.req_imm[2*DATA_W-1:DATA_W]
                           : bus.req_imm[DATA_W-1:0];
          alu_cin_d  = win ? bus.req_cin[15:8]
                           : bus.req_cin[7:0];
          alu_code_d = win ? bus.req_code[2*CODE_W-1:CODE_W]
                           : bus.req_code[CODE_W-1:0];
          rsp_id_d   = win;
          alu_en_d   = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        // alu_rdy deliberately ignored here.
        state_d = WAIT;
`ifdef ALU_ISSUE_ARBITER_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (bus.alu_rdy) begin
          rsp_res_d   = bus.alu_result;
          rsp_ex_d    = bus.alu_ex_result;
          rsp_cout_d  = bus.alu_cout;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
`ifdef ALU_ISSUE_ARBITER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_res_d   = '0;
          rsp_ex_d    = '0;
          rsp_cout_d  = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_d        = ~rsp_id_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      alu_en_q    <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_imm_q   <= '0;
      alu_cin_q   <= '0;
      alu_code_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_res_q   <= '0;
      rsp_ex_q    <= '0;
      rsp_cout_q  <= 1'b0;
`ifdef ALU_ISSUE_ARBITER_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      alu_en_q    <= alu_en_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_imm_q   <= alu_imm_d;
      alu_cin_q   <= alu_cin_d;
      alu_code_q  <= alu_code_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_res_q   <= rsp_res_d;
      rsp_ex_q    <= rsp_ex_d;
      rsp_cout_q  <= rsp_cout_d;
`ifdef ALU_ISSUE_ARBITER_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign bus.alu_en        = alu_en_q;
  assign bus.alu_a         = alu_a_q;
  assign bus.alu_b         = alu_b_q;
  assign bus.alu_imm       = alu_imm_q;
  assign bus.alu_cin       = alu_cin_q;
  assign bus.alu_code      = alu_code_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_result    = rsp_res_q;
  assign bus.rsp_ex_result = rsp_ex_q;
  assign bus.rsp_cout      = rsp_cout_q;
`ifdef ALU_ISSUE_ARBITER_TIMEOUT_EN
  assign bus.rsp_err       = rsp_err_q;
`else
  assign bus.rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: random and directed operations,
// responses checked by a decoupled scoreboard monitor.
module tb_alu_issue_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  alu_issue_arbiter_if #(.DATA_W(64), .CODE_W(5)) bus ();

  alu_issue_arbiter #(
    .DATA_W(64), .CODE_W(5), .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic        id;
    logic [63:0] res;
    logic [63:0] ex;
    logic        cout;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   m_rr   = 0;

  logic [63:0] op_a [2];
  logic [63:0] op_b [2];
  logic [63:0] op_i [2];
  logic [7:0]  op_c [2];
  logic [4:0]  op_k [2];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behaviour of the stand-in ALU: sum, xor mix, carry of a+b+cin[0].
  function automatic exp_t alu_fn(input logic [63:0] a, b, imm,
                                  input logic [7:0] cin,
                                  input logic [4:0] code);
    exp_t e;
    logic [64:0] s;
    s      = {1'b0, a} + {1'b0, b} + 65'(cin[0]);
    e.id   = 1'b0;
    e.res  = a + b;
    e.ex   = a ^ imm ^ 64'(code);
    e.cout = s[64];
    e.err  = 1'b0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 2; i++) begin
      op_a[i] = {$urandom, $urandom};
      op_b[i] = {$urandom, $urandom};
      op_i[i] = {$urandom, $urandom};
      op_c[i] = 8'($urandom);
      op_k[i] = 5'($urandom);
    end
  endtask

  task automatic drive_ops(input logic [1:0] v);
    bus.req_a     = {op_a[1], op_a[0]};
    bus.req_b     = {op_b[1], op_b[0]};
    bus.req_imm   = {op_i[1], op_i[0]};
    bus.req_cin   = {op_c[1], op_c[0]};
    bus.req_code  = {op_k[1], op_k[0]};
    bus.req_valid = v;
  endtask

  task automatic garbage_alu();
    bus.alu_result    = {$urandom, $urandom};
    bus.alu_ex_result = {$urandom, $urandom};
    bus.alu_cout      = 1'($urandom);
  endtask

  // Grant then ISSUE; returns in the first WAIT cycle (posedge+1).
  task automatic grant_issue(input logic [1:0] v, input bit spur,
                             output int w);
    drive_ops(v);
    w = v[m_rr] ? m_rr : 1 - m_rr;
    @(negedge clk);
    chk("grant", 64'(bus.req_ready), 64'(w == 1 ? 2 : 1));
    tick();
    bus.req_valid = v & ((w == 1) ? 2'b01 : 2'b10);
    if (spur) begin
      bus.alu_rdy = 1'b1;
      garbage_alu();
    end
    @(negedge clk);
    chk("alu_en_issue", 64'(bus.alu_en), 64'd1);
    chk("ready_issue", 64'(bus.req_ready), 64'd0);
    chk("alu_a", bus.alu_a, op_a[w]);
    chk("alu_b", bus.alu_b, op_b[w]);
    chk("alu_imm", bus.alu_imm, op_i[w]);
    chk("alu_cin", 64'(bus.alu_cin), 64'(op_c[w]));
    chk("alu_code", 64'(bus.alu_code), 64'(op_k[w]));
    tick();
    bus.alu_rdy = 1'b0;
    garbage_alu();
  endtask

  task automatic consume(input int w);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    tick();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b00;
    m_rr = 1 - w;
  endtask

  task automatic run_op(input logic [1:0] v, input int lat,
                        input int bp, input bit spur);
    int   w;
    exp_t e;
    if (v == 2'b00) begin
      drive_ops(v);
      @(negedge clk);
      chk("no_grant", 64'(bus.req_ready), 64'd0);
      tick();
      return;
    end
    grant_issue(v, spur, w);
    e    = alu_fn(op_a[w], op_b[w], op_i[w], op_c[w], op_k[w]);
    e.id = w[0];
    sb.push_back(e);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk("wait_en", 64'(bus.alu_en), 64'd0);
      chk("wait_valid", 64'(bus.rsp_valid), 64'd0);
      chk("wait_ready", 64'(bus.req_ready), 64'd0);
      chk("wait_a_hold", bus.alu_a, op_a[w]);
      tick();
    end
    begin
      exp_t r;
      r = alu_fn(bus.alu_a, bus.alu_b, bus.alu_imm,
                 bus.alu_cin, bus.alu_code);
      bus.alu_result    = r.res;
      bus.alu_ex_result = r.ex;
      bus.alu_cout      = r.cout;
      bus.alu_rdy       = 1'b1;
    end
    tick();
    bus.alu_rdy = 1'b0;
    garbage_alu();
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_ready", 64'(bus.req_ready), 64'd0);
      chk("bp_en", 64'(bus.alu_en), 64'd0);
      chk("bp_result", bus.rsp_result, e.res);
      chk("bp_id", 64'(bus.rsp_id), 64'(e.id));
      tick();
    end
    consume(w);
  endtask

  // Scoreboard monitor: compare each accepted response.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id %0d expected none",
                 bus.rsp_id);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_id", 64'(bus.rsp_id), 64'(mon_e.id));
        chk("rsp_result", bus.rsp_result, mon_e.res);
        chk("rsp_ex", bus.rsp_ex_result, mon_e.ex);
        chk("rsp_cout", 64'(bus.rsp_cout), 64'(mon_e.cout));
        chk("rsp_err", 64'(bus.rsp_err), 64'(mon_e.err));
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_en"}, 64'(bus.alu_en), 64'd0);
    chk({tag, "_a"}, bus.alu_a, 64'd0);
    chk({tag, "_b"}, bus.alu_b, 64'd0);
    chk({tag, "_imm"}, bus.alu_imm, 64'd0);
    chk({tag, "_cin"}, 64'(bus.alu_cin), 64'd0);
    chk({tag, "_code"}, 64'(bus.alu_code), 64'd0);
    chk({tag, "_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_id"}, 64'(bus.rsp_id), 64'd0);
    chk({tag, "_res"}, bus.rsp_result, 64'd0);
    chk({tag, "_ex"}, bus.rsp_ex_result, 64'd0);
    chk({tag, "_cout"}, 64'(bus.rsp_cout), 64'd0);
    chk({tag, "_err"}, 64'(bus.rsp_err), 64'd0);
    chk({tag, "_ready"}, 64'(bus.req_ready), 64'd0);
  endtask

  initial begin
    int w;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    bus.alu_rdy   = 1'b0;
    rand_ops();
    drive_ops(2'b11);
    garbage_alu();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    tick();
    rst = 1'b0;
    bus.req_valid = 2'b00;

    // Single request, ALU ready 3 cycles after the start pulse.
    rand_ops();
    op_a[0] = 64'h12345678;
    op_b[0] = 64'h1;
    op_k[0] = 5'b00110;
    run_op(2'b01, 2, 0, 1'b0);

    // Contention: four back-to-back operations with both requesting.
    for (int i = 0; i < 4; i++) begin
      rand_ops();
      run_op(2'b11, $urandom_range(0, 3), 0, 1'b0);
    end

    // Backpressure for 10 cycles.
    rand_ops();
    run_op(2'b10, 1, 10, 1'b0);

    // Spurious rdy during ISSUE.
    rand_ops();
    run_op(2'b01, 2, 0, 1'b1);

    // rdy on the last cycle before a timeout would expire.
    rand_ops();
    run_op(2'b11, 7, 1, 1'b0);

    // Random mix.
    for (int i = 0; i < 40; i++) begin
      rand_ops();
      run_op(2'($urandom_range(0, 3)), $urandom_range(0, 5),
             $urandom_range(0, 3), 1'($urandom));
    end

    // Reset mid-WAIT after serving slot 0 so the pointer is at 1.
    rand_ops();
    run_op(2'b01, 0, 0, 1'b0);
    rand_ops();
    grant_issue(2'b11, 1'b0, w);
    chk("pre_rst_winner", 64'(w), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = 2'b00;
    bus.alu_rdy   = 1'b1;
    tick();
    bus.alu_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_rdy_valid", 64'(bus.rsp_valid), 64'd0);
      tick();
    end
    m_rr = 0;
    rand_ops();
    run_op(2'b11, 1, 0, 1'b0);

    // ALU that never answers.
    rand_ops();
    grant_issue(2'b01, 1'b0, w);
`ifdef ALU_ISSUE_ARBITER_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("tmo_early", 64'(bus.rsp_valid), 64'd0);
      tick();
    end
    @(negedge clk);
    chk("tmo_valid", 64'(bus.rsp_valid), 64'd1);
    sb.push_back('{id: 1'b0, res: 64'd0, ex: 64'd0,
                   cout: 1'b0, err: 1'b1});
    tick();
    consume(w);
`else
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (bus.rsp_valid) seen = 1'b1;
      end
      chk("no_tmo_valid", 64'(seen), 64'd0);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid = 2'b00;
    m_rr = 0;
`endif
    rand_ops();
    run_op(2'b11, 0, 0, 1'b0);

    repeat (3) @(posedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
